// File: rtl/apu_divn_if.sv
// Configuration write and counter readback bus for the apu_divn channel bank.
interface apu_divn_if #(
    parameter int unsigned PERIOD_BITS = 16,
    parameter int unsigned CH_BITS     = 2
);
    logic                   wr_en;
    logic [CH_BITS-1:0]     wr_ch;
    logic [PERIOD_BITS-1:0] wr_period;
    logic                   wr_oneshot;
    logic [CH_BITS-1:0]     rd_ch;
    logic [PERIOD_BITS-1:0] rd_cnt;

    modport master (
        output wr_en, wr_ch, wr_period, wr_oneshot, rd_ch,
        input  rd_cnt
    );

    modport slave (
        input  wr_en, wr_ch, wr_period, wr_oneshot, rd_ch,
        output rd_cnt
    );
endinterface

// File: rtl/apu_divn.sv
// Bank of independent programmable tick dividers with loop / one-shot modes,
// per-channel reload and halt, and a readback mux for the live counter.
module apu_divn #(
    parameter int unsigned CHANNELS    = 4,
    parameter int unsigned PERIOD_BITS = 16,
    parameter int unsigned CH_BITS     = 2
) (
    input  logic                clk_in,
    input  logic                rst_in,
    input  logic [CHANNELS-1:0] pulse_in,
    input  logic [CHANNELS-1:0] reload_in,
    input  logic [CHANNELS-1:0] halt_in,
    output logic [CHANNELS-1:0] pulse_out,
    output logic [CHANNELS-1:0] active_out,
    apu_divn_if.slave           cfg
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    state_e                 state_q  [CHANNELS];
    state_e                 state_d  [CHANNELS];
    logic [PERIOD_BITS-1:0] period_q [CHANNELS];
    logic [PERIOD_BITS-1:0] period_d [CHANNELS];
    logic [PERIOD_BITS-1:0] cnt_q    [CHANNELS];
    logic [PERIOD_BITS-1:0] cnt_d    [CHANNELS];
    logic                   oneshot_q[CHANNELS];
    logic                   oneshot_d[CHANNELS];
    logic [CHANNELS-1:0]    pulse_d;

    // Per-channel next state; a same-cycle write bypasses into the reload value.
    always_comb begin
        pulse_d = '0;
        for (int c = 0; c < int'(CHANNELS); c++) begin
            logic                   wr_hit;
            logic [PERIOD_BITS-1:0] eff_period;

            state_d[c]   = state_q[c];
            period_d[c]  = period_q[c];
            cnt_d[c]     = cnt_q[c];
            oneshot_d[c] = oneshot_q[c];

            wr_hit     = cfg.wr_en && (cfg.wr_ch == CH_BITS'(c));
            eff_period = wr_hit ? cfg.wr_period : period_q[c];

            if (wr_hit) begin
                period_d[c]  = cfg.wr_period;
                oneshot_d[c] = cfg.wr_oneshot;
            end

            if (reload_in[c]) begin
                cnt_d[c]   = eff_period;
                state_d[c] = RUN;
            end else if ((state_q[c] == RUN) && !halt_in[c] && pulse_in[c]) begin
                if (cnt_q[c] != '0) begin
                    cnt_d[c] = cnt_q[c] - PERIOD_BITS'(1);
                end else begin
                    pulse_d[c] = 1'b1;
                    if (oneshot_q[c]) begin
                        state_d[c] = IDLE;
                        cnt_d[c]   = '0;
                    end else begin
                        cnt_d[c] = eff_period;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            for (int c = 0; c < int'(CHANNELS); c++) begin
                state_q[c]   <= IDLE;
                period_q[c]  <= '0;
                cnt_q[c]     <= '0;
                oneshot_q[c] <= 1'b0;
            end
        end else begin
            for (int c = 0; c < int'(CHANNELS); c++) begin
                state_q[c]   <= state_d[c];
                period_q[c]  <= period_d[c];
                cnt_q[c]     <= cnt_d[c];
                oneshot_q[c] <= oneshot_d[c];
            end
        end
    end

    // Underflow pulse is same-cycle by design; reset forces both flags low.
    always_comb begin
        pulse_out  = '0;
        active_out = '0;
        for (int c = 0; c < int'(CHANNELS); c++) begin
            pulse_out[c]  = pulse_d[c] && !rst_in;
            active_out[c] = (state_q[c] == RUN) && !rst_in;
        end
    end

    // Unpopulated channel indices read back as zero.
    always_comb begin
        cfg.rd_cnt = '0;
        for (int c = 0; c < int'(CHANNELS); c++) begin
            if (cfg.rd_ch == CH_BITS'(c)) begin
                cfg.rd_cnt = cnt_q[c];
            end
        end
    end

endmodule

// File: doc/apu_divn.md
APU_DIVN -- requirements
Module: apu_divn

Interface
REQ-001 SHALL have parameter CHANNELS, default 4, meaning number of independent divider channels (1..16).
REQ-002 SHALL have parameter PERIOD_BITS, default 16, meaning counter and period width per channel.
REQ-003 SHALL have parameter CH_BITS, default 2, meaning channel index width; must satisfy 2**CH_BITS >= CHANNELS.
REQ-004 SHALL have port clk_in  input  1  system clock; one clock, all state on rising edge.
REQ-005 SHALL have port rst_in  input  1  reset, synchronous and active-high.
REQ-006 SHALL have port pulse_in  input  CHANNELS  per-channel input tick.
REQ-007 SHALL have port reload_in  input  CHANNELS  per-channel reload/start strobe.
REQ-008 SHALL have port halt_in  input  CHANNELS  per-channel freeze.
REQ-009 SHALL have port wr_en  input  1  configuration write strobe.
REQ-010 SHALL have port wr_ch  input  CH_BITS  channel addressed by the write.
REQ-011 SHALL have port wr_period  input  PERIOD_BITS  new period value.
REQ-012 SHALL have port wr_oneshot  input  1  new mode: 0 loop, 1 one-shot.
REQ-013 SHALL have port rd_ch  input  CH_BITS  channel selected for counter readback.
REQ-014 SHALL have port pulse_out  output  CHANNELS  per-channel divided pulse.
REQ-015 SHALL have port active_out  output  CHANNELS  per-channel RUN state flag.
REQ-016 SHALL have port rd_cnt  output  PERIOD_BITS  current counter of channel rd_ch.

Function
REQ-017 Each channel SHALL hold period_q, oneshot_q, cnt_q and a 2-state FSM {IDLE, RUN}.
REQ-018 wr_en with wr_ch < CHANNELS SHALL update period_q and oneshot_q of that channel at the next edge; wr_ch >= CHANNELS SHALL be ignored.
REQ-019 A period write SHALL NOT change cnt_q or state; it takes effect at the next reload or loop underflow.
REQ-020 reload_in[c] SHALL load cnt_q[c] with the effective period and enter RUN, from either state, regardless of halt_in and pulse_in.
REQ-021 Effective period SHALL be wr_period when the same-cycle write targets channel c (bypass), else period_q[c].
REQ-022 In IDLE, pulse_in SHALL be ignored, cnt_q held, pulse_out low.
REQ-023 In RUN with halt_in[c] high and no reload, cnt_q and state SHALL hold and pulse_out[c] SHALL be low.
REQ-024 In RUN, not halted, no reload: pulse_in[c] with cnt_q[c] != 0 SHALL decrement cnt_q by 1; no pulse.
REQ-025 In RUN, not halted, no reload: pulse_in[c] with cnt_q[c] == 0 SHALL assert pulse_out[c] combinationally in that same cycle.
REQ-026 On that underflow, loop mode SHALL reload the effective period and stay RUN; one-shot SHALL go IDLE with cnt_q = 0.
REQ-027 pulse_out[c] SHALL be low in any cycle where reload_in[c] is high (reload suppresses the pulse).
REQ-028 Period 0 in loop mode SHALL pulse on every pulse_in; period P SHALL give one pulse per P+1 ticks.
REQ-029 Decrement SHALL be modulo-free: cnt_q never wraps below 0; no other arithmetic on cnt_q.
REQ-030 active_out[c] SHALL equal (state == RUN), registered.
REQ-031 rd_cnt SHALL be a combinational mux of cnt_q[rd_ch]; rd_ch >= CHANNELS SHALL return 0.
REQ-032 Channels SHALL be fully independent; simultaneous events on different channels SHALL not interact.

Reset
REQ-033 rst_in high at an edge SHALL set all period_q = 0, oneshot_q = 0, cnt_q = 0, state IDLE; pulse_out and active_out SHALL be 0 during reset.
REQ-034 rst_in SHALL take priority over reload_in, wr_en and pulse_in in the same cycle, including mid-count.

Verification
REQ-035 Write ch1 period=3 loop, reload ch1, pulse_in[1] constant -> pulse_out[1] high every 4th cycle, rd_cnt(ch1) cycles 3,2,1,0.
REQ-036 Write ch2 period=2 one-shot, reload, 5 ticks -> exactly one pulse on 3rd tick, then active_out[2]=0, rd_cnt=0, no further pulses.
REQ-037 ch0 RUN cnt=0, pulse_in and reload_in same cycle with wr_ch=0 wr_period=7 -> pulse_out[0]=0, cnt_q[0]=7 next cycle.
REQ-038 ch3 period=5 mid-count at 2, halt_in[3] high 4 cycles with ticks -> cnt stays 2, no pulse; release -> continues 1,0, pulse.
REQ-039 All channels RUN with distinct periods, rst_in pulsed mid-count -> all outputs 0, active_out=0, subsequent ticks produce no pulses until reload.
REQ-040 wr_en with wr_ch=CHANNELS (when 2**CH_BITS > CHANNELS) -> no channel config changes; rd_ch out of range -> rd_cnt=0.
